// File: rtl/fir_complex_decim.sv
// -----------------------------------------------------------------------------
// fir_complex_decim
//   Complex-coefficient FIR filter with integer decimation for the FM receiver
//   channel stage. Paired I/Q samples are popped from two first-word-fall-through
//   input FIFOs. One filtered I/Q pair is pushed to two output FIFOs for every
//   DECIM accepted input pairs. The taps are evaluated one per clock in a single
//   shared complex multiply-accumulate.
//
//   Optional build macro: FIR_CMPLX_SAT_EN
//     undefined : accumulators are DATA_SIZE bits and wrap modulo 2^DATA_SIZE
//     defined   : accumulators are widened; each output channel is clamped to
//                 the signed DATA_SIZE range when written. An internal sticky
//                 flag (sat_sticky_q) records that a clamp occurred.
//
// Ports
//   clock            in   1          rising-edge clock
//   reset            in   1          asynchronous, active-low
//   xreal_in_empty   in   1          input I FIFO empty
//   xreal_in_rd_en   out  1          pop input I FIFO
//   xreal_in_dout    in   DATA_SIZE  input I head word
//   ximag_in_empty   in   1          input Q FIFO empty
//   ximag_in_rd_en   out  1          pop input Q FIFO
//   ximag_in_dout    in   DATA_SIZE  input Q head word
//   yreal_out_full   in   1          output I FIFO full
//   yreal_out_wr_en  out  1          push output I FIFO
//   yreal_out_din    out  DATA_SIZE  output I word
//   yimag_out_full   in   1          output Q FIFO full
//   yimag_out_wr_en  out  1          push output Q FIFO
//   yimag_out_din    out  DATA_SIZE  output Q word
// -----------------------------------------------------------------------------
module fir_complex_decim #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned TAPS      = 20,
    parameter int unsigned DECIM     = 1,
    parameter int unsigned BITS      = 10,
    parameter logic [0:TAPS-1][DATA_SIZE-1:0] COEFFS_REAL = '0,
    parameter logic [0:TAPS-1][DATA_SIZE-1:0] COEFFS_IMAG = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 xreal_in_empty,
    output logic                 xreal_in_rd_en,
    input  logic [DATA_SIZE-1:0] xreal_in_dout,
    input  logic                 ximag_in_empty,
    output logic                 ximag_in_rd_en,
    input  logic [DATA_SIZE-1:0] ximag_in_dout,
    input  logic                 yreal_out_full,
    output logic                 yreal_out_wr_en,
    output logic [DATA_SIZE-1:0] yreal_out_din,
    input  logic                 yimag_out_full,
    output logic                 yimag_out_wr_en,
    output logic [DATA_SIZE-1:0] yimag_out_din
);

    localparam int unsigned PROD_W = 2 * DATA_SIZE;
    localparam int unsigned SUM_W  = PROD_W + 1;
    localparam int unsigned DCNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int unsigned PCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
`ifdef FIR_CMPLX_SAT_EN
    localparam int unsigned ACC_W  = DATA_SIZE + $clog2(TAPS) + 1;
`else
    localparam int unsigned ACC_W  = DATA_SIZE;
`endif

    typedef enum logic [1:0] {
        S_LOAD,
        S_MAC,
        S_WRITE
    } state_t;

    state_t                    state_q, state_d;
    logic [PCNT_W-1:0]         pcnt_q, pcnt_d;
    logic [DCNT_W-1:0]         dcnt_q, dcnt_d;
    logic signed [ACC_W-1:0]   acc_r_q, acc_r_d;
    logic signed [ACC_W-1:0]   acc_i_q, acc_i_d;

    logic signed [DATA_SIZE-1:0] hist_r_q [TAPS];
    logic signed [DATA_SIZE-1:0] hist_i_q [TAPS];

    logic pop;
    logic push;

    // Current tap operands
    logic signed [DATA_SIZE-1:0] tap_xr, tap_xi, tap_hr, tap_hi;
    logic signed [PROD_W-1:0]    p_rr, p_ii, p_ri, p_ir;
    logic signed [SUM_W-1:0]     sum_r, sum_i;
    logic signed [DATA_SIZE-1:0] dq_r, dq_i;

    // Divide by 2^BITS rounding toward zero: negative values are biased by
    // 2^BITS-1 before the arithmetic shift so they do not round toward -inf.
    function automatic logic signed [DATA_SIZE-1:0] dq(input logic signed [SUM_W-1:0] p);
        logic signed [SUM_W-1:0] bias;
        logic signed [SUM_W-1:0] adj;
        bias = (SUM_W'(1) <<< BITS) - SUM_W'(1);
        adj  = p;
        if (p[SUM_W-1]) begin
            adj = p + bias;
        end
        return DATA_SIZE'(adj >>> BITS);
    endfunction

    assign tap_xr = hist_r_q[dcnt_q];
    assign tap_xi = hist_i_q[dcnt_q];
    assign tap_hr = COEFFS_REAL[dcnt_q];
    assign tap_hi = COEFFS_IMAG[dcnt_q];

    assign p_rr = PROD_W'(tap_xr) * PROD_W'(tap_hr);
    assign p_ii = PROD_W'(tap_xi) * PROD_W'(tap_hi);
    assign p_ri = PROD_W'(tap_xr) * PROD_W'(tap_hi);
    assign p_ir = PROD_W'(tap_xi) * PROD_W'(tap_hr);

    // One extra bit so the product sum/difference cannot overflow before scaling
    assign sum_r = SUM_W'(p_rr) - SUM_W'(p_ii);
    assign sum_i = SUM_W'(p_ri) + SUM_W'(p_ir);

    assign dq_r = dq(sum_r);
    assign dq_i = dq(sum_i);

    // Both FIFOs of a pair are always popped/pushed together; a lone ready side
    // is left untouched. The pop is also held off while reset is asserted.
    assign xreal_in_rd_en  = pop;
    assign ximag_in_rd_en  = pop;
    assign yreal_out_wr_en = push;
    assign yimag_out_wr_en = push;

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        dcnt_d  = dcnt_q;
        acc_r_d = acc_r_q;
        acc_i_d = acc_i_q;
        pop     = 1'b0;
        push    = 1'b0;
        case (state_q)
            S_LOAD: begin
                pop = reset && !xreal_in_empty && !ximag_in_empty;
                if (pop) begin
                    if (pcnt_q == PCNT_W'(DECIM - 1)) begin
                        pcnt_d  = '0;
                        dcnt_d  = '0;
                        state_d = S_MAC;
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
            end
            S_MAC: begin
                acc_r_d = acc_r_q + ACC_W'(dq_r);
                acc_i_d = acc_i_q + ACC_W'(dq_i);
                if (dcnt_q == DCNT_W'(TAPS - 1)) begin
                    dcnt_d  = '0;
                    state_d = S_WRITE;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            S_WRITE: begin
                push = !yreal_out_full && !yimag_out_full;
                if (push) begin
                    acc_r_d = '0;
                    acc_i_d = '0;
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_LOAD;
            pcnt_q  <= '0;
            dcnt_q  <= '0;
            acc_r_q <= '0;
            acc_i_q <= '0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            dcnt_q  <= dcnt_d;
            acc_r_q <= acc_r_d;
            acc_i_q <= acc_i_d;
        end
    end

    // Sample history: slot 0 is the newest pair
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                hist_r_q[k] <= '0;
                hist_i_q[k] <= '0;
            end
        end else if (pop) begin
            hist_r_q[0] <= xreal_in_dout;
            hist_i_q[0] <= ximag_in_dout;
            for (int unsigned k = 1; k < TAPS; k++) begin
                hist_r_q[k] <= hist_r_q[k-1];
                hist_i_q[k] <= hist_i_q[k-1];
            end
        end
    end

`ifdef FIR_CMPLX_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_SIZE-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic clip_r, clip_i;
    logic sat_sticky_q, sat_sticky_d;

    assign clip_r = (acc_r_q > SAT_MAX) || (acc_r_q < SAT_MIN);
    assign clip_i = (acc_i_q > SAT_MAX) || (acc_i_q < SAT_MIN);

    always_comb begin
        yreal_out_din = DATA_SIZE'(acc_r_q);
        yimag_out_din = DATA_SIZE'(acc_i_q);
        if (clip_r) begin
            yreal_out_din = acc_r_q[ACC_W-1] ? DATA_SIZE'(SAT_MIN) : DATA_SIZE'(SAT_MAX);
        end
        if (clip_i) begin
            yimag_out_din = acc_i_q[ACC_W-1] ? DATA_SIZE'(SAT_MIN) : DATA_SIZE'(SAT_MAX);
        end
    end

    assign sat_sticky_d = sat_sticky_q || (push && (clip_r || clip_i));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sat_sticky_q <= 1'b0;
        end else begin
            sat_sticky_q <= sat_sticky_d;
        end
    end
`else
    assign yreal_out_din = acc_r_q;
    assign yimag_out_din = acc_i_q;
`endif

endmodule

// File: tb/tb_fir_complex_decim.sv
// -----------------------------------------------------------------------------
// tb_fir_complex_decim
//   Directed bench for fir_complex_decim. Instance dut_a (DECIM=1) covers the
//   impulse, truncation, handshake, lone-FIFO and mid-MAC reset cases; instance
//   dut_b (DECIM=8) covers decimation with a DC input. FIFOs are modelled by
//   queues; inputs change on the falling edge, outputs are sampled 2 units later.
// -----------------------------------------------------------------------------
module tb_fir_complex_decim;

    localparam int DS = 32;
    localparam int NT = 20;

    // Symmetric low-pass style set: sum = 0x4B2, centre taps 0x257
    localparam logic [0:NT-1][DS-1:0] HR = {
        -32'sd1,  32'sd0,   32'sd3,   -32'sd2,  32'sd3,  -32'sd5, 32'sd8, -32'sd13,
         32'sd9,  32'sd599, 32'sd599,  32'sd9, -32'sd13,  32'sd8, -32'sd5, 32'sd3,
        -32'sd2,  32'sd3,   32'sd0,   -32'sd1
    };
    // h_i[k] = k - 10
    localparam logic [0:NT-1][DS-1:0] HI = {
        -32'sd10, -32'sd9, -32'sd8, -32'sd7, -32'sd6, -32'sd5, -32'sd4, -32'sd3,
        -32'sd2,  -32'sd1,  32'sd0,  32'sd1,  32'sd2,  32'sd3,  32'sd4,  32'sd5,
         32'sd6,   32'sd7,  32'sd8,  32'sd9
    };

    logic clock = 1'b0;
    logic reset = 1'b0;

    logic          a_xr_e = 1'b1, a_xi_e = 1'b1, a_xr_rd, a_xi_rd;
    logic [DS-1:0] a_xr_d = '0, a_xi_d = '0;
    logic          a_yr_f = 1'b0, a_yi_f = 1'b0, a_yr_wr, a_yi_wr;
    logic [DS-1:0] a_yr_d, a_yi_d;

    logic          b_xr_e = 1'b1, b_xi_e = 1'b1, b_xr_rd, b_xi_rd;
    logic [DS-1:0] b_xr_d = '0, b_xi_d = '0;
    logic          b_yr_f = 1'b0, b_yi_f = 1'b0, b_yr_wr, b_yi_wr;
    logic [DS-1:0] b_yr_d, b_yi_d;

    logic [DS-1:0] a_qr[$], a_qi[$], a_or[$], a_oi[$];
    logic [DS-1:0] b_qr[$], b_qi[$], b_or[$], b_oi[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int a_pops = 0, a_pop_cyc = 0, a_lat = 0, a_mm = 0;
    int b_pops = 0, b_mm = 0, b_grp = 0, b_gap = 0, b_viol = 0;
    bit a_pend = 1'b0, b_pend = 1'b0;

    fir_complex_decim #(
        .DATA_SIZE(DS), .TAPS(NT), .DECIM(1), .BITS(10),
        .COEFFS_REAL(HR), .COEFFS_IMAG(HI)
    ) dut_a (
        .clock(clock), .reset(reset),
        .xreal_in_empty(a_xr_e), .xreal_in_rd_en(a_xr_rd), .xreal_in_dout(a_xr_d),
        .ximag_in_empty(a_xi_e), .ximag_in_rd_en(a_xi_rd), .ximag_in_dout(a_xi_d),
        .yreal_out_full(a_yr_f), .yreal_out_wr_en(a_yr_wr), .yreal_out_din(a_yr_d),
        .yimag_out_full(a_yi_f), .yimag_out_wr_en(a_yi_wr), .yimag_out_din(a_yi_d)
    );

    fir_complex_decim #(
        .DATA_SIZE(DS), .TAPS(NT), .DECIM(8), .BITS(10),
        .COEFFS_REAL(HR), .COEFFS_IMAG(HI)
    ) dut_b (
        .clock(clock), .reset(reset),
        .xreal_in_empty(b_xr_e), .xreal_in_rd_en(b_xr_rd), .xreal_in_dout(b_xr_d),
        .ximag_in_empty(b_xi_e), .ximag_in_rd_en(b_xi_rd), .ximag_in_dout(b_xi_d),
        .yreal_out_full(b_yr_f), .yreal_out_wr_en(b_yr_wr), .yreal_out_din(b_yr_d),
        .yimag_out_full(b_yi_f), .yimag_out_wr_en(b_yi_wr), .yimag_out_din(b_yi_d)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // FIFO models for dut_a: pop what the DUT took at the last rising edge,
    // present the new heads, then sample handshakes before the next edge.
    always @(negedge clock) begin
        if (a_pend) begin
            void'(a_qr.pop_front());
            void'(a_qi.pop_front());
            a_pops++;
        end
        a_xr_e = (a_qr.size() == 0);
        a_xi_e = (a_qi.size() == 0);
        if (!a_xr_e) a_xr_d = a_qr[0];
        if (!a_xi_e) a_xi_d = a_qi[0];
        #2;
        cyc++;
        a_pend = a_xr_rd && a_xi_rd;
        if (a_xr_rd != a_xi_rd) a_mm++;
        if (a_pend) a_pop_cyc = cyc;
        if (a_yr_wr != a_yi_wr) a_mm++;
        if (a_yr_wr && a_yi_wr) begin
            a_or.push_back(a_yr_d);
            a_oi.push_back(a_yi_d);
            a_lat = cyc - a_pop_cyc;
        end
    end

    // FIFO models for dut_b plus a pop-gap watch after every 8th pop
    always @(negedge clock) begin
        if (b_pend) begin
            void'(b_qr.pop_front());
            void'(b_qi.pop_front());
            b_pops++;
        end
        b_xr_e = (b_qr.size() == 0);
        b_xi_e = (b_qi.size() == 0);
        if (!b_xr_e) b_xr_d = b_qr[0];
        if (!b_xi_e) b_xi_d = b_qi[0];
        #2;
        b_pend = b_xr_rd && b_xi_rd;
        if (b_xr_rd != b_xi_rd) b_mm++;
        if (b_yr_wr != b_yi_wr) b_mm++;
        if (b_gap > 0) begin
            if (b_pend) b_viol++;
            b_gap--;
        end else if (b_pend) begin
            b_grp++;
            if (b_grp == 8) begin
                b_grp = 0;
                b_gap = NT + 1;
            end
        end
        if (b_yr_wr && b_yi_wr) begin
            b_or.push_back(b_yr_d);
            b_oi.push_back(b_yi_d);
        end
    end

    task automatic push_a(input logic [31:0] r, input logic [31:0] i);
        a_qr.push_back(r);
        a_qi.push_back(i);
    endtask

    task automatic wait_a(input int n, input int budget);
        int t = 0;
        while (a_or.size() < n && t < budget) begin
            @(negedge clock); #3;
            t++;
        end
        repeat (3) @(negedge clock);
        #3;
        check("a_out_count", a_or.size(), n);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_rd_r"}, {31'd0, a_xr_rd}, 32'd0);
        check({tag, "_rd_i"}, {31'd0, a_xi_rd}, 32'd0);
        check({tag, "_wr_r"}, {31'd0, a_yr_wr}, 32'd0);
        check({tag, "_wr_i"}, {31'd0, a_yi_wr}, 32'd0);
        check({tag, "_din_r"}, a_yr_d, 32'd0);
        check({tag, "_din_i"}, a_yi_d, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t;
        int n0;
        repeat (3) @(negedge clock);
        #3;
        check_idle("reset");
        check("reset_b_wr", {31'd0, b_yr_wr}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Decimation: 160 DC samples into the DECIM=8 instance -> 20 outputs
        for (int k = 0; k < 160; k++) begin
            b_qr.push_back(32'h400);
            b_qi.push_back(32'h0);
        end
        t = 0;
        while (b_or.size() < 20 && t < 2000) begin
            @(negedge clock); #3;
            t++;
        end
        repeat (40) @(negedge clock);
        #3;
        check("dec_out_count", b_or.size(), 32'd20);
        check("dec_pops", b_pops, 32'd160);
        check("dec_pop_in_mac", b_viol, 32'd0);
        check("dec_pair_sync", b_mm, 32'd0);
        for (int k = 0; k < 20 && k < b_or.size(); k++) begin
            check($sformatf("dec_yr[%0d]", k), b_or[k],
                  (k == 0) ? -32'sd7 : 32'h4B2);
            check($sformatf("dec_yi[%0d]", k), b_oi[k],
                  (k == 0) ? -32'sd52 : (k == 1) ? -32'sd40 : -32'sd10);
        end

        // Impulse on I: y[k] = h[k]
        push_a(32'h400, 32'h0);
        for (int k = 1; k < NT; k++) push_a(32'h0, 32'h0);
        wait_a(NT, 1000);
        check("latency", a_lat, NT + 1);
        for (int k = 0; k < NT && k < a_or.size(); k++) begin
            check($sformatf("impI_yr[%0d]", k), a_or[k], HR[k]);
            check($sformatf("impI_yi[%0d]", k), a_oi[k], HI[k]);
        end
        a_or.delete(); a_oi.delete();

        // Impulse on Q: y_r[k] = -h_i[k], y_i[k] = h_r[k]
        push_a(32'h0, 32'h400);
        for (int k = 1; k < NT; k++) push_a(32'h0, 32'h0);
        wait_a(NT, 1000);
        for (int k = 0; k < NT && k < a_or.size(); k++) begin
            check($sformatf("impQ_yr[%0d]", k), a_or[k], -HI[k]);
            check($sformatf("impQ_yi[%0d]", k), a_oi[k], HR[k]);
        end
        a_or.delete(); a_oi.delete();

        // x_r = -1: every |product| < 1024 must round toward zero
        push_a(32'hFFFFFFFF, 32'h0);
        for (int k = 1; k < NT; k++) push_a(32'h0, 32'h0);
        wait_a(NT, 1000);
        for (int k = 0; k < NT && k < a_or.size(); k++) begin
            check($sformatf("trunc_yr[%0d]", k), a_or[k], 32'h0);
            check($sformatf("trunc_yi[%0d]", k), a_oi[k], 32'h0);
        end
        a_or.delete(); a_oi.delete();

        // Output Q FIFO full: result (-2, -20) must be held, not pushed
        @(negedge clock);
        a_yi_f = 1'b1;
        push_a(32'h800, 32'h0);
        repeat (30) @(negedge clock);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock); #3;
            check("hold_wr_r", {31'd0, a_yr_wr}, 32'd0);
            check("hold_wr_i", {31'd0, a_yi_wr}, 32'd0);
            check("hold_din_r", a_yr_d, -32'sd2);
            check("hold_din_i", a_yi_d, -32'sd20);
        end
        check("hold_no_push", a_or.size(), 32'd0);
        @(negedge clock);
        a_yi_f = 1'b0;
        repeat (5) @(negedge clock);
        #3;
        check("release_count", a_or.size(), 32'd1);
        if (a_or.size() > 0) begin
            check("release_yr", a_or[0], -32'sd2);
            check("release_yi", a_oi[0], -32'sd20);
        end
        a_or.delete(); a_oi.delete();

        // Only the Q input has data: nothing may be popped
        a_qi.push_back(32'h400);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock); #3;
            check("lone_rd_r", {31'd0, a_xr_rd}, 32'd0);
            check("lone_rd_i", {31'd0, a_xi_rd}, 32'd0);
        end
        check("lone_q_kept", a_qi.size(), 32'd1);
        a_qr.push_back(32'h0);
        wait_a(1, 200);
        if (a_or.size() > 0) begin
            check("lone_pair_yr", a_or[0], 32'd10);
            check("lone_pair_yi", a_oi[0], -32'sd19);
        end
        a_or.delete(); a_oi.delete();

        // Reset while tap 7 is being accumulated
        n0 = a_pops;
        push_a(32'h400, 32'h0);
        t = 0;
        while (a_pops == n0 && t < 50) begin
            @(negedge clock); #3;
            t++;
        end
        check("rst_pop_seen", a_pops, n0 + 1);
        repeat (7) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        #3;
        check_idle("rst_mid");
        @(negedge clock);
        reset = 1'b1;
        repeat (30) @(negedge clock);
        #3;
        check("rst_no_push", a_or.size(), 32'd0);
        push_a(32'h400, 32'h0);
        wait_a(1, 200);
        if (a_or.size() > 0) begin
            check("rst_clean_yr", a_or[0], HR[0]);
            check("rst_clean_yi", a_oi[0], HI[0]);
        end
        check("a_pair_sync", a_mm, 32'd0);
`ifdef FIR_CMPLX_SAT_EN
        check("sat_sticky_clear", {31'd0, dut_a.sat_sticky_q}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
